// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// mem_access_unit
//
// Single-outstanding load/store unit sitting between a core-side request
// channel and a simple byte-addressed RAM. Each access walks
// IDLE -> ACCESS -> RESP -> IDLE, so back-to-back accesses take at least
// three cycles. Out-of-range addresses (>= ADDR_LIMIT) never reach the RAM
// and answer with rsp_exc = 10.
//
// Build option: define MAU_MISALIGN_TRAP_EN to turn misaligned half/word
// accesses and the reserved size 11 into rsp_exc = 01 faults. Without it,
// size 11 behaves as a word and half/word addresses are silently aligned down.
//
// Ports
//   clk, clr                 clock, asynchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_write, req_size,     store flag, size (00 byte, 01 half, 10 word),
//   req_signed, req_addr,    load sign-extension, byte address,
//   req_wdata                right-aligned store data
//   ram_addr, ram_din,       RAM byte address, write data,
//   ram_mode, ram_we,        access mode, write enable,
//   ram_sel, ram_dout        select, combinational read data
//   rsp_valid / rsp_ready    response handshake
//   rsp_rdata, rsp_exc       load result, exception code
module mem_access_unit #(
   parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [11:0] ram_addr,
   output logic [31:0] ram_din,
   output logic [1:0]  ram_mode,
   output logic        ram_we,
   output logic        ram_sel,
   input  logic [31:0] ram_dout,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_exc
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state, state_next;
   logic        lat_write;
   logic        lat_signed;
   logic [1:0]  lat_size;
   logic [1:0]  lat_exc;
   logic [11:0] lat_addr;
   logic [31:0] lat_wdata;
   logic        accept;
   logic [1:0]  fault;
   logic [11:0] eff_addr;
   logic [1:0]  eff_size;

   assign accept = req_valid && req_ready;

   // Classify the incoming request and work out the address and mode the RAM
   // will actually see. Range is checked on the full 32-bit address before
   // anything else so an out-of-range access always reports 10.
   always_comb begin
      fault    = 2'b00;
      eff_addr = req_addr[11:0];
      eff_size = req_size;
`ifdef MAU_MISALIGN_TRAP_EN
      if (req_addr >= ADDR_LIMIT) begin
         fault = 2'b10;
      end else if ((req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                   (req_size == 2'b11)) begin
         fault = 2'b01;
      end
`else
      if (req_addr >= ADDR_LIMIT) begin
         fault = 2'b10;
      end
      if (req_size == 2'b11) begin
         eff_size = 2'b10;
      end
      case (eff_size)
         2'b01:   eff_addr = {req_addr[11:1], 1'b0};
         2'b10:   eff_addr = {req_addr[11:2], 2'b00};
         default: eff_addr = req_addr[11:0];
      endcase
`endif
   end

   // State register. Reset drops any in-flight access immediately, which
   // also pulls ram_sel/ram_we low combinationally so no write can commit.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic plus the handshake and RAM strobes. The RAM is only
   // touched during the single ACCESS cycle, and only for non-faulted requests.
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      ram_sel    = 1'b0;
      ram_we     = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            ram_sel    = (lat_exc == 2'b00);
            ram_we     = (lat_exc == 2'b00) && lat_write;
            state_next = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Request capture. These registers feed the RAM address/data/mode outputs
   // directly, so those outputs simply hold their last values between accesses.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         lat_write  <= 1'b0;
         lat_signed <= 1'b0;
         lat_size   <= 2'b10;
         lat_exc    <= 2'b00;
         lat_addr   <= 12'h000;
         lat_wdata  <= 32'h0000_0000;
      end else if (accept) begin
         lat_write  <= req_write;
         lat_signed <= req_signed;
         lat_size   <= eff_size;
         lat_exc    <= fault;
         lat_addr   <= eff_addr;
         lat_wdata  <= req_wdata;
      end
   end

   // Load result capture. The RAM returns byte/half data zero-extended, so
   // only the signed narrow cases need work; stores and faults return zero.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         rsp_rdata <= 32'h0000_0000;
      end else if (state == ACCESS) begin
         if (lat_write || lat_exc != 2'b00) begin
            rsp_rdata <= 32'h0000_0000;
         end else begin
            case (lat_size)
               2'b00:   rsp_rdata <= lat_signed ? {{24{ram_dout[7]}}, ram_dout[7:0]} : ram_dout;
               2'b01:   rsp_rdata <= lat_signed ? {{16{ram_dout[15]}}, ram_dout[15:0]} : ram_dout;
               default: rsp_rdata <= ram_dout;
            endcase
         end
      end
   end

   assign ram_addr = lat_addr;
   assign ram_din  = lat_wdata;
   assign ram_mode = lat_size;
   assign rsp_exc  = lat_exc;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_LIMIT, default 32'h0000_1000, first out-of-range byte address.
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have clr  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have req_valid  input  1  load/store request present.
REQ-005 SHALL have req_ready  output  1  request accepted when req_valid && req_ready.
REQ-006 SHALL have req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have req_signed  input  1  sign-extend load result.
REQ-009 SHALL have req_addr  input  32  byte address.
REQ-010 SHALL have req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have ram_addr  output  12  RAM byte address.
REQ-012 SHALL have ram_din  output  32  RAM write data.
REQ-013 SHALL have ram_mode  output  2  RAM access mode (same encoding as req_size).
REQ-014 SHALL have ram_we, ram_sel  output  1 each  RAM write enable, RAM select.
REQ-015 SHALL have ram_dout  input  32  RAM combinational read data, zero-extended in low bits for byte/half.
REQ-016 SHALL have rsp_valid  output  1  response present; rsp_ready  input  1  consumer accepts.
REQ-017 SHALL have rsp_rdata  output  32  load result (0 for stores and faults).
REQ-018 SHALL have rsp_exc  output  2  00 none, 01 misaligned, 10 out of range.

Function
REQ-019 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; req_ready = (state == IDLE).
REQ-020 On acceptance SHALL latch write, size, signed, addr, wdata and classify fault; IDLE -> ACCESS.
REQ-021 Fault priority: req_addr >= ADDR_LIMIT gives 10; else misalignment (REQ-030) gives 01.
REQ-022 In ACCESS, non-faulted: ram_sel = 1, ram_addr = latched addr[11:0], ram_mode = size, ram_din = wdata, ram_we = write; faulted: ram_sel = ram_we = 0.
REQ-023 Outside ACCESS: ram_sel = ram_we = 0, ram_addr/ram_din/ram_mode hold latched values.
REQ-024 In ACCESS SHALL register rsp_rdata: byte signed = {24{ram_dout[7]}, ram_dout[7:0]}; half signed = {16{ram_dout[15]}, ram_dout[15:0]}; unsigned or word = ram_dout; store or fault = 0; ACCESS -> RESP.
REQ-025 rsp_valid = (state == RESP); rsp_rdata, rsp_exc stable while rsp_valid && !rsp_ready.
REQ-026 RESP -> IDLE on rsp_ready; no new request accepted in the same cycle (minimum 3 cycles per access).
REQ-027 Latency: accept at edge N, RAM write commits at edge N+1, rsp_valid high after edge N+1.
REQ-028 Store SHALL cause exactly one ram_we cycle; load SHALL cause none.

Reset
REQ-029 On clr: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_exc = 00, ram_we = ram_sel = 0, ram_addr = 0, ram_din = 0, ram_mode = 10; in-flight access dropped, no write issued.

Configuration
REQ-030 Macro MAU_MISALIGN_TRAP_EN defined: half with addr[0] = 1, word with addr[1:0] != 00, or size 11 gives rsp_exc = 01 and no RAM access.
REQ-031 Macro undefined: no misalignment fault; size 11 treated as word; half address forced to addr & ~1, word address forced to addr & ~3 before access; rsp_exc never 01.

Verification
REQ-032 Store word 0xDEADBEEF @0x010, then load word @0x010 -> one ram_we pulse, rsp_rdata = 0xDEADBEEF, rsp_exc = 00.
REQ-033 Store byte 0x80 @0x013, load byte signed @0x013 -> 0xFFFFFF80; load unsigned -> 0x00000080.
REQ-034 Load half signed @0x012 after storing 0x8001 there -> 0xFFFF8001.
REQ-035 Load word @0x1000 -> rsp_exc = 10, rsp_rdata = 0, ram_sel never 1.
REQ-036 Word load @0x011: with MAU_MISALIGN_TRAP_EN -> rsp_exc = 01, no RAM access; without -> reads word @0x010, rsp_exc = 00.
REQ-037 Hold rsp_ready = 0 for 5 cycles -> rsp_valid and data stable, req_ready = 0; assert clr in ACCESS of a store -> no ram_we, all outputs at REQ-029 values.
